tcam_match_scanner: RTL



---
 rtl/tcam_match_scanner.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/tcam_match_scanner.sv
// Sequential multi-match TCAM scanner: streams every set match-line index of a lookup, one per beat, in priority order.
// Optional m_count (popcount of the accepted vector) is enabled by defining TCAM_SCAN_HIT_COUNT_EN.
module tcam_match_scanner #(
    parameter int WIDTH     = 64,
    parameter int LSB_FIRST = 0,
    parameter int MAX_HITS  = 0,
    localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CNT_W    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] s_match,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [IDX_W-1:0] m_index,
    output logic             m_hit,
    output logic             m_last,
    output logic             m_trunc,
`ifdef TCAM_SCAN_HIT_COUNT_EN
    output logic [CNT_W-1:0] m_count,
`endif
    output logic             m_valid,
    input  logic             m_ready
);

    localparam int          PAD_W = 1 << IDX_W;
    localparam logic [31:0] MAX_U = MAX_HITS;

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    // Binary-tree priority encoder over the zero-padded vector; returns {hit, index}.
    // Each level folds node pairs in place, recording the chosen half in index bit lv.
    function automatic logic [IDX_W:0] encode(input logic [PAD_W-1:0] vec);
        logic [PAD_W-1:0] v;
        logic [IDX_W-1:0] ix [PAD_W];
        logic [IDX_W-1:0] t;
        logic             sel;
        v = vec;
        for (int n = 0; n < PAD_W; n++) ix[n] = '0;
        for (int lv = 0; lv < IDX_W; lv++) begin
            for (int j = 0; j < (PAD_W >> (lv + 1)); j++) begin
                if (LSB_FIRST != 0) sel = !v[2*j] && v[2*j+1];
                else                sel = v[2*j+1];
                t     = sel ? ix[2*j+1] : ix[2*j];
                t[lv] = sel;
                ix[j] = t;
                v[j]  = v[2*j] | v[2*j+1];
            end
        end
        return {v[0], ix[0]};
    endfunction

`ifdef TCAM_SCAN_HIT_COUNT_EN
    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] vec);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int n = 0; n < WIDTH; n++) c = c + CNT_W'(vec[n]);
        return c;
    endfunction
`endif

    state_e             state_q, state_d;
    logic               s_ready_q, s_ready_d;
    logic               m_valid_q, m_valid_d;
    logic [IDX_W-1:0]   m_index_q, m_index_d;
    logic               m_hit_q, m_hit_d;
    logic               m_last_q, m_last_d;
    logic               m_trunc_q, m_trunc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef TCAM_SCAN_HIT_COUNT_EN
    logic [CNT_W-1:0]   count_q, count_d;
`endif

    logic [WIDTH-1:0]   src;
    logic [WIDTH-1:0]   rem_next;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_hit;
    logic               load;
    logic               hit_limit;

    // The encoder reads the fresh vector while idle and the leftover hits while scanning.
    always_comb begin
        src                = (state_q == IDLE) ? s_match : rem_q;
        {enc_hit, enc_idx} = encode(PAD_W'(src));
        rem_next           = src;
        if (enc_hit) rem_next[enc_idx] = 1'b0;
    end

    // NOTE: every signal gets its hold value first so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        m_index_d = m_index_q;
        m_hit_d   = m_hit_q;
        m_last_d  = m_last_q;
        m_trunc_d = m_trunc_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
`ifdef TCAM_SCAN_HIT_COUNT_EN
        count_d   = count_q;
`endif
        load      = 1'b0;
        hit_limit = 1'b0;

        case (state_q)
            IDLE: begin
                if (s_valid && s_ready_q) begin
                    state_d = SCAN;
                    load    = 1'b1;
                    cnt_d   = CNT_W'(1);
`ifdef TCAM_SCAN_HIT_COUNT_EN
                    count_d = popcount(s_match);
`endif
                end
            end
            SCAN: begin
                if (m_ready && m_last_q) begin
                    state_d   = IDLE;
                    m_index_d = '0;
                    m_hit_d   = 1'b0;
                    m_last_d  = 1'b0;
                    m_trunc_d = 1'b0;
                    rem_d     = '0;
                    cnt_d     = '0;
`ifdef TCAM_SCAN_HIT_COUNT_EN
                    count_d   = '0;
`endif
                end else if (m_ready) begin
                    load  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            hit_limit = (MAX_HITS != 0) && (32'(cnt_d) == MAX_U);
            m_index_d = enc_idx;
            m_hit_d   = enc_hit;
            rem_d     = rem_next;
            m_last_d  = (rem_next == '0) || hit_limit;
            m_trunc_d = hit_limit && (rem_next != '0);
        end

        s_ready_d = (state_d == IDLE);
        m_valid_d = (state_d == SCAN);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            m_index_q <= '0;
            m_hit_q   <= 1'b0;
            m_last_q  <= 1'b0;
            m_trunc_q <= 1'b0;
            rem_q     <= '0;
            cnt_q     <= '0;
`ifdef TCAM_SCAN_HIT_COUNT_EN
            count_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            m_index_q <= m_index_d;
            m_hit_q   <= m_hit_d;
            m_last_q  <= m_last_d;
            m_trunc_q <= m_trunc_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
`ifdef TCAM_SCAN_HIT_COUNT_EN
            count_q   <= count_d;
`endif
        end
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_index = m_index_q;
    assign m_hit   = m_hit_q;
    assign m_last  = m_last_q;
    assign m_trunc = m_trunc_q;
`ifdef TCAM_SCAN_HIT_COUNT_EN
    assign m_count = count_q;
`endif

endmodule
